// File: rtl/ex_sequencer.sv
// Execute-stage issue/control sequencer: decoder handshake, queue-full stalls,
// zone write strobes, fault/redirect vectoring, wrong-path skip and retire count.
module ex_sequencer #(
    parameter int                C_XLEN     = 32,
    parameter logic [C_XLEN-1:0] C_TRAP_VEC = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    input  logic              ids_dav_i,
    output logic              ids_ack_o,
    input  logic              ids_sofr_i,
    input  logic              ids_ins_ferr_i,
    input  logic              ids_ins_uerr_i,
    input  logic              ids_cond_i,
    input  logic              ids_jump_i,
    input  logic [1:0]        ids_zone_i,
    input  logic [C_XLEN-1:0] ids_pc_i,
    input  logic [C_XLEN-1:0] ids_target_i,
    input  logic              lsq_lq_full_i,
    input  logic              lsq_sq_full_i,
    output logic              regd_wr_o,
    output logic              lsq_lq_wr_o,
    output logic              lsq_sq_wr_o,
    output logic              hvec_vec_strobe_o,
    output logic [C_XLEN-1:0] hvec_vec_o,
    output logic [C_XLEN-1:0] hvec_pc_o,
    output logic [63:0]       instret_o
);

    localparam logic [1:0] ZONE_LOADQ  = 2'd2;
    localparam logic [1:0] ZONE_STOREQ = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SKIP = 1'b1
    } state_t;

    state_t            state_reg;
    logic [3:1]        zone_wr_reg;
    logic              vec_strobe_reg;
    logic [C_XLEN-1:0] vec_reg;
    logic [C_XLEN-1:0] vec_pc_reg;
    logic [63:0]       instret_reg;

    logic              in_run;
    logic              on_path;
    logic              block;
    logic              exec;
    logic              fault;
    logic              retire;
    logic              commit;
    logic              vec_take;
    logic [C_XLEN-1:0] cause_off;
    logic [C_XLEN-1:0] fault_vec;
    logic [C_XLEN-1:0] vec_next;
    logic [3:1]        zone_hit;

    assign in_run  = (state_reg == ST_RUN);
    // A sofr instruction is the first one back on the correct path after a redirect.
    assign on_path = in_run | ids_sofr_i;

    assign block = ((ids_zone_i == ZONE_LOADQ)  & lsq_lq_full_i) |
                   ((ids_zone_i == ZONE_STOREQ) & lsq_sq_full_i);

    // Wrong-path instructions are drained even into a full queue since they never write it.
    assign ids_ack_o = clk_en_i & ids_dav_i & ~reset_i & ~(block & on_path);

    assign exec     = ids_ack_o & on_path;
    assign fault    = ids_ins_ferr_i | ids_ins_uerr_i;
    assign retire   = exec & ~fault;
    assign commit   = retire & ids_cond_i;
    assign vec_take = exec & (fault | (ids_cond_i & ids_jump_i));

    // Fetch error outranks an undefined instruction: cause 1 vs cause 2.
    assign cause_off = ids_ins_ferr_i ? C_XLEN'(4) : C_XLEN'(8);
    assign fault_vec = C_TRAP_VEC + cause_off;
    assign vec_next  = fault ? fault_vec : ids_target_i;

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_zone
            assign zone_hit[gi] = commit & (ids_zone_i == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg      <= ST_RUN;
            zone_wr_reg    <= '0;
            vec_strobe_reg <= 1'b0;
            vec_reg        <= '0;
            vec_pc_reg     <= '0;
            instret_reg    <= '0;
        end else if (clk_en_i) begin
            zone_wr_reg    <= zone_hit;
            vec_strobe_reg <= vec_take;
            if (vec_take) begin
                vec_reg    <= vec_next;
                vec_pc_reg <= ids_pc_i;
            end
            if (retire) begin
                instret_reg <= instret_reg + 64'd1;
            end
            if (exec) begin
                state_reg <= vec_take ? ST_SKIP : ST_RUN;
            end
        end
    end

    assign regd_wr_o         = zone_wr_reg[1];
    assign lsq_lq_wr_o       = zone_wr_reg[2];
    assign lsq_sq_wr_o       = zone_wr_reg[3];
    assign hvec_vec_strobe_o = vec_strobe_reg;
    assign hvec_vec_o        = vec_reg;
    assign hvec_pc_o         = vec_pc_reg;
    assign instret_o         = instret_reg;

endmodule

// File: tb/tb_ex_sequencer.sv
// Bench for ex_sequencer: directed vector table, then random stimulus checked
// against a rule-level reference model.
module tb_ex_sequencer;

    localparam int          XLEN = 32;
    localparam logic [31:0] TRAP = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            reset_i, clk_en_i, ids_dav_i, ids_ack_o, ids_sofr_i;
    logic            ids_ins_ferr_i, ids_ins_uerr_i, ids_cond_i, ids_jump_i;
    logic [1:0]      ids_zone_i;
    logic [XLEN-1:0] ids_pc_i, ids_target_i;
    logic            lsq_lq_full_i, lsq_sq_full_i;
    logic            regd_wr_o, lsq_lq_wr_o, lsq_sq_wr_o, hvec_vec_strobe_o;
    logic [XLEN-1:0] hvec_vec_o, hvec_pc_o;
    logic [63:0]     instret_o;

    always #5 clk = ~clk;

    ex_sequencer #(.C_XLEN(XLEN), .C_TRAP_VEC(TRAP)) dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ids_dav_i(ids_dav_i), .ids_ack_o(ids_ack_o), .ids_sofr_i(ids_sofr_i),
        .ids_ins_ferr_i(ids_ins_ferr_i), .ids_ins_uerr_i(ids_ins_uerr_i),
        .ids_cond_i(ids_cond_i), .ids_jump_i(ids_jump_i), .ids_zone_i(ids_zone_i),
        .ids_pc_i(ids_pc_i), .ids_target_i(ids_target_i),
        .lsq_lq_full_i(lsq_lq_full_i), .lsq_sq_full_i(lsq_sq_full_i),
        .regd_wr_o(regd_wr_o), .lsq_lq_wr_o(lsq_lq_wr_o), .lsq_sq_wr_o(lsq_sq_wr_o),
        .hvec_vec_strobe_o(hvec_vec_strobe_o), .hvec_vec_o(hvec_vec_o),
        .hvec_pc_o(hvec_pc_o), .instret_o(instret_o)
    );

    // ctl = {rst, en, dav, sofr, ferr, uerr, cond, jump}; full = {lq_full, sq_full}
    // exp = {ack, regd_wr, lq_wr, sq_wr, vec_strobe} (outputs after the edge, ack before)
    typedef struct {
        logic [7:0]  ctl;
        logic [1:0]  zone;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  full;
        logic [4:0]  exp;
        logic [31:0] vec;
        logic [31:0] vpc;
        logic [63:0] ir;
    } row_t;

    row_t rows[$];
    int   n_pass = 0;
    int   n_total = 0;

    // reference model state
    bit          m_skip;
    bit [3:0]    m_pulse;
    bit          m_vs;
    bit [31:0]   m_vec, m_vpc;
    bit [63:0]   m_ir;

    function automatic row_t mk(logic [7:0] ctl, logic [1:0] zone, logic [31:0] pc,
                                logic [31:0] tgt, logic [1:0] full, logic [4:0] exp,
                                logic [31:0] vec, logic [31:0] vpc, logic [63:0] ir);
        row_t r;
        r.ctl = ctl; r.zone = zone; r.pc = pc; r.tgt = tgt; r.full = full;
        r.exp = exp; r.vec = vec; r.vpc = vpc; r.ir = ir;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic drive(input logic [7:0] ctl, input logic [1:0] zone,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] full);
        {reset_i, clk_en_i, ids_dav_i, ids_sofr_i,
         ids_ins_ferr_i, ids_ins_uerr_i, ids_cond_i, ids_jump_i} = ctl;
        ids_zone_i = zone; ids_pc_i = pc; ids_target_i = tgt;
        {lsq_lq_full_i, lsq_sq_full_i} = full;
    endtask

    task automatic chk_outputs(input int idx, input logic [3:0] strobes,
                               input logic [31:0] vec, input logic [31:0] vpc,
                               input logic [63:0] ir);
        chk("regd_wr", idx, 64'(regd_wr_o), 64'(strobes[3]));
        chk("lq_wr", idx, 64'(lsq_lq_wr_o), 64'(strobes[2]));
        chk("sq_wr", idx, 64'(lsq_sq_wr_o), 64'(strobes[1]));
        chk("vec_strobe", idx, 64'(hvec_vec_strobe_o), 64'(strobes[0]));
        chk("vec", idx, 64'(hvec_vec_o), 64'(vec));
        chk("vec_pc", idx, 64'(hvec_pc_o), 64'(vpc));
        chk("instret", idx, instret_o, ir);
    endtask

    // Expected ack: stalled only for a full queue when the instruction would really execute.
    function automatic bit model_ack(input logic [7:0] ctl, input logic [1:0] zone,
                                     input logic [1:0] full);
        bit blocked, live;
        blocked = (zone == 2'd2 && full[1]) || (zone == 2'd3 && full[0]);
        live    = !m_skip || ctl[4];
        return ctl[6] && ctl[5] && !ctl[7] && !(blocked && live);
    endfunction

    task automatic model_edge(input logic [7:0] ctl, input logic [1:0] zone,
                              input logic [31:0] pc, input logic [31:0] tgt, input bit acc);
        bit live;
        live = !m_skip || ctl[4];
        if (ctl[7]) begin
            m_skip = 0; m_pulse = '0; m_vs = 0; m_vec = '0; m_vpc = '0; m_ir = '0;
        end else if (ctl[6]) begin
            m_pulse = '0;
            m_vs = 0;
            if (acc && live) begin
                if (ctl[3] || ctl[2]) begin
                    m_vs = 1; m_vec = TRAP + (ctl[3] ? 32'd1 : 32'd2) * 32'd4;
                    m_vpc = pc; m_skip = 1;
                end else begin
                    m_ir = m_ir + 64'd1;
                    m_skip = 0;
                    if (ctl[1]) begin
                        m_pulse[zone] = 1'b1;
                        if (ctl[0]) begin
                            m_vs = 1; m_vec = tgt; m_vpc = pc; m_skip = 1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        // reset with a pending instruction, then first instruction
        rows.push_back(mk(8'b1110_0010, 2'd1, 32'h0,   32'h0,   2'b00, 5'b00000, 32'h0,   32'h0,   64'd0));
        rows.push_back(mk(8'b1110_0010, 2'd1, 32'h0,   32'h0,   2'b00, 5'b00000, 32'h0,   32'h0,   64'd0));
        rows.push_back(mk(8'b0110_0010, 2'd1, 32'h10,  32'h0,   2'b00, 5'b11000, 32'h0,   32'h0,   64'd1));
        rows.push_back(mk(8'b0100_0010, 2'd1, 32'h14,  32'h0,   2'b00, 5'b00000, 32'h0,   32'h0,   64'd1));
        // load queue backpressure for 3 cycles, store queue, cross-queue full
        rows.push_back(mk(8'b0110_0010, 2'd2, 32'h20,  32'h0,   2'b10, 5'b00000, 32'h0,   32'h0,   64'd1));
        rows.push_back(mk(8'b0110_0010, 2'd2, 32'h20,  32'h0,   2'b10, 5'b00000, 32'h0,   32'h0,   64'd1));
        rows.push_back(mk(8'b0110_0010, 2'd2, 32'h20,  32'h0,   2'b10, 5'b00000, 32'h0,   32'h0,   64'd1));
        rows.push_back(mk(8'b0110_0010, 2'd2, 32'h20,  32'h0,   2'b00, 5'b10100, 32'h0,   32'h0,   64'd2));
        rows.push_back(mk(8'b0100_0010, 2'd2, 32'h24,  32'h0,   2'b00, 5'b00000, 32'h0,   32'h0,   64'd2));
        rows.push_back(mk(8'b0110_0010, 2'd3, 32'h28,  32'h0,   2'b01, 5'b00000, 32'h0,   32'h0,   64'd2));
        rows.push_back(mk(8'b0110_0010, 2'd3, 32'h28,  32'h0,   2'b00, 5'b10010, 32'h0,   32'h0,   64'd3));
        rows.push_back(mk(8'b0110_0010, 2'd2, 32'h2c,  32'h0,   2'b01, 5'b10100, 32'h0,   32'h0,   64'd4));
        // double fault, wrong-path drain (even when blocked), sofr resumes
        rows.push_back(mk(8'b0110_1110, 2'd1, 32'h200, 32'h0,   2'b00, 5'b10001, 32'h4,   32'h200, 64'd4));
        rows.push_back(mk(8'b0110_0010, 2'd1, 32'h204, 32'h0,   2'b00, 5'b10000, 32'h4,   32'h200, 64'd4));
        rows.push_back(mk(8'b0110_0010, 2'd1, 32'h208, 32'h0,   2'b00, 5'b10000, 32'h4,   32'h200, 64'd4));
        rows.push_back(mk(8'b0110_0010, 2'd2, 32'h20c, 32'h0,   2'b10, 5'b10000, 32'h4,   32'h200, 64'd4));
        rows.push_back(mk(8'b0111_0010, 2'd1, 32'h210, 32'h0,   2'b00, 5'b11000, 32'h4,   32'h200, 64'd5));
        // undefined instruction; blocked sofr stalls in SKIP
        rows.push_back(mk(8'b0110_0110, 2'd1, 32'h300, 32'h0,   2'b00, 5'b10001, 32'h8,   32'h300, 64'd5));
        rows.push_back(mk(8'b0111_0010, 2'd2, 32'h304, 32'h0,   2'b10, 5'b00000, 32'h8,   32'h300, 64'd5));
        rows.push_back(mk(8'b0111_0010, 2'd2, 32'h304, 32'h0,   2'b00, 5'b10100, 32'h8,   32'h300, 64'd6));
        // jump-and-link, then untaken jump stays in RUN
        rows.push_back(mk(8'b0110_0011, 2'd1, 32'h100, 32'h400, 2'b00, 5'b11001, 32'h400, 32'h100, 64'd7));
        rows.push_back(mk(8'b0111_0010, 2'd1, 32'h400, 32'h0,   2'b00, 5'b11000, 32'h400, 32'h100, 64'd8));
        rows.push_back(mk(8'b0110_0001, 2'd1, 32'h100, 32'h400, 2'b00, 5'b10000, 32'h400, 32'h100, 64'd9));
        rows.push_back(mk(8'b0110_0010, 2'd1, 32'h104, 32'h0,   2'b00, 5'b11000, 32'h400, 32'h100, 64'd10));
        // clock enable low while the strobe is high
        rows.push_back(mk(8'b0110_0011, 2'd0, 32'h140, 32'h500, 2'b00, 5'b10001, 32'h500, 32'h140, 64'd11));
        rows.push_back(mk(8'b0011_0010, 2'd1, 32'h144, 32'h0,   2'b00, 5'b00001, 32'h500, 32'h140, 64'd11));
        rows.push_back(mk(8'b0011_0010, 2'd1, 32'h144, 32'h0,   2'b00, 5'b00001, 32'h500, 32'h140, 64'd11));
        rows.push_back(mk(8'b0011_0010, 2'd1, 32'h144, 32'h0,   2'b00, 5'b00001, 32'h500, 32'h140, 64'd11));
        rows.push_back(mk(8'b0100_0010, 2'd1, 32'h144, 32'h0,   2'b00, 5'b00000, 32'h500, 32'h140, 64'd11));
        // reset mid-SKIP, reset while strobe high, reset with enable low
        rows.push_back(mk(8'b1110_0010, 2'd1, 32'h148, 32'h0,   2'b00, 5'b00000, 32'h0,   32'h0,   64'd0));
        rows.push_back(mk(8'b0110_0010, 2'd1, 32'h50,  32'h0,   2'b00, 5'b11000, 32'h0,   32'h0,   64'd1));
        rows.push_back(mk(8'b0110_0011, 2'd1, 32'h180, 32'h600, 2'b00, 5'b11001, 32'h600, 32'h180, 64'd2));
        rows.push_back(mk(8'b1100_0010, 2'd1, 32'h184, 32'h0,   2'b00, 5'b00000, 32'h0,   32'h0,   64'd0));
        rows.push_back(mk(8'b0110_0010, 2'd1, 32'h60,  32'h0,   2'b00, 5'b11000, 32'h0,   32'h0,   64'd1));
        rows.push_back(mk(8'b0110_0010, 2'd0, 32'h64,  32'h0,   2'b00, 5'b10000, 32'h0,   32'h0,   64'd2));
        rows.push_back(mk(8'b1000_0000, 2'd0, 32'h0,   32'h0,   2'b00, 5'b00000, 32'h0,   32'h0,   64'd0));

        foreach (rows[i]) begin
            drive(rows[i].ctl, rows[i].zone, rows[i].pc, rows[i].tgt, rows[i].full);
            #1;
            chk("ack", i, 64'(ids_ack_o), 64'(rows[i].exp[4]));
            @(posedge clk);
            #1;
            chk_outputs(i, rows[i].exp[3:0], rows[i].vec, rows[i].vpc, rows[i].ir);
        end

        // last table row was a reset: model starts from the reset state
        m_skip = 0; m_pulse = '0; m_vs = 0; m_vec = '0; m_vpc = '0; m_ir = '0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  ctl;
            logic [1:0]  zone, full;
            logic [31:0] pc, tgt;
            bit          acc;
            ctl[7] = ($urandom_range(0, 63) == 0);
            ctl[6] = ($urandom_range(0, 7) != 0);
            ctl[5] = ($urandom_range(0, 3) != 0);
            ctl[4] = ($urandom_range(0, 3) == 0);
            ctl[3] = ($urandom_range(0, 15) == 0);
            ctl[2] = ($urandom_range(0, 15) == 0);
            ctl[1] = ($urandom_range(0, 3) != 0);
            ctl[0] = ($urandom_range(0, 3) == 0);
            zone   = 2'($urandom_range(0, 3));
            full   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            pc     = $urandom;
            tgt    = $urandom;
            drive(ctl, zone, pc, tgt, full);
            #1;
            acc = model_ack(ctl, zone, full);
            chk("rnd_ack", i, 64'(ids_ack_o), 64'(acc));
            model_edge(ctl, zone, pc, tgt, acc);
            @(posedge clk);
            #1;
            chk_outputs(i, {m_pulse[1], m_pulse[2], m_pulse[3], m_vs}, m_vec, m_vpc, m_ir);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
